// File: rtl/data_mem_bridge.sv
// Bridges the core's single-cycle memory-stage request onto a req/gnt + rvalid
// data bus, stalling the core until the transaction completes, errors or times out.
module data_mem_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int BE_W          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [BE_W-1:0]   core_mask,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    output logic              core_ack,
    output logic              core_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [BE_W-1:0]   bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic              core_ack_q, core_ack_d;
    logic              core_err_q, core_err_d;
    logic              take_resp;
    logic              timed_out;

    // Word accesses must be word aligned, halfwords halfword aligned; an empty mask is never legal.
    function automatic logic misaligned(input logic [BE_W-1:0] mask, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (mask == '0)
            bad = 1'b1;
        else if (mask == {BE_W{1'b1}} && lo != 2'b00)
            bad = 1'b1;
        else if ((mask == BE_W'(4'b0011) || mask == BE_W'(4'b1100)) && lo[0])
            bad = 1'b1;
        return bad;
    endfunction

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        core_rdata_d = core_rdata_q;
        core_ack_d   = 1'b0;
        core_err_d   = 1'b0;
        take_resp    = 1'b0;

        case (state_q)
            IDLE: begin
                if (core_req) begin
                    bus_we_d    = core_we;
                    bus_be_d    = core_mask;
                    bus_addr_d  = {core_addr[ADDR_W-1:2], 2'b00};
                    bus_wdata_d = core_wdata;
                    cnt_d       = '0;
                    if (misaligned(core_mask, core_addr[1:0])) begin
                        state_d    = DONE;
                        core_ack_d = 1'b1;
                        core_err_d = 1'b1;
                    end else begin
                        state_d   = REQ;
                        bus_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    if (bus_rvalid)
                        take_resp = 1'b1;
                    else
                        state_d = WAIT;
                end else if (timed_out) begin
                    bus_req_d  = 1'b0;
                    state_d    = DONE;
                    core_ack_d = 1'b1;
                    core_err_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_rvalid) begin
                    take_resp = 1'b1;
                end else if (timed_out) begin
                    state_d    = DONE;
                    core_ack_d = 1'b1;
                    core_err_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Only a clean load response may overwrite the data the core last loaded.
        if (take_resp) begin
            state_d    = DONE;
            core_ack_d = 1'b1;
            core_err_d = bus_err;
            if (!bus_we_q && !bus_err)
                core_rdata_d = bus_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            core_rdata_q <= '0;
            core_ack_q   <= 1'b0;
            core_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            core_rdata_q <= core_rdata_d;
            core_ack_q   <= core_ack_d;
            core_err_q   <= core_err_d;
        end
    end

    // The core must freeze in the very cycle its request appears, hence the combinational term in IDLE.
    assign core_stall = (state_q == IDLE) ? core_req : (state_q == REQ || state_q == WAIT);

    assign core_rdata = core_rdata_q;
    assign core_ack   = core_ack_q;
    assign core_err   = core_err_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_be     = bus_be_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: table of transactions played through a bus responder,
// completion results checked against a scoreboard, plus reset corner sequences.
module tb_data_mem_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we;
    logic [3:0]    core_mask;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_stall, core_ack, core_err;
    logic          bus_req, bus_we;
    logic [3:0]    bus_be;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_gnt, bus_rvalid, bus_err;
    logic [DW-1:0] bus_rdata;

    always #5 clk = ~clk;

    data_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_mask(core_mask),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall), .core_ack(core_ack), .core_err(core_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    // gw: REQ cycles before gnt; rw: cycles from gnt to rvalid (0 = same cycle)
    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gw;
        int          rw;
        logic [31:0] rdata;
        logic        berr;
        logic        nobus;
        logic        tmo;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t vt[12];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && core_ack) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack");
            end else begin
                e = sb.pop_front();
                chk("ack_err", 64'(core_err), 64'(e.err));
                chk("ack_rdata", 64'(core_rdata), 64'(e.rdata));
            end
        end
    end

    task automatic run_txn(input vec_t t, input string nm);
        int   req_cycles = 0;
        int   after = 0;
        int   ack_c = -1;
        int   exp_c;
        int   exp_req;
        bit   granted = 0;
        exp_t e;
        exp_c   = t.nobus ? 0 : (t.tmo ? TMO : 1 + t.gw + t.rw);
        exp_req = t.nobus ? 0 : (t.tmo ? TMO : t.gw + 1);
        @(negedge clk);
        core_req   = 1'b1;
        core_we    = t.we;
        core_mask  = t.mask;
        core_addr  = t.addr;
        core_wdata = t.wdata;
        e.err   = t.exp_err;
        e.rdata = t.exp_rdata;
        sb.push_back(e);
        #1 chk({nm, "_stall_idle"}, 64'(core_stall), 64'd1);
        for (int c = 0; c < TMO + 20; c++) begin
            @(negedge clk);
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            bus_rdata  = $urandom;
            if (core_ack) begin
                ack_c = c;
                break;
            end
            chk({nm, "_stall_busy"}, 64'(core_stall), 64'd1);
            if (bus_req) begin
                chk({nm, "_bus_addr"}, 64'(bus_addr), 64'({t.addr[31:2], 2'b00}));
                chk({nm, "_bus_be"}, 64'(bus_be), 64'(t.mask));
                chk({nm, "_bus_we"}, 64'(bus_we), 64'(t.we));
                chk({nm, "_bus_wdata"}, 64'(bus_wdata), 64'(t.wdata));
                if (!t.tmo && req_cycles == t.gw) begin
                    bus_gnt = 1'b1;
                    granted = 1;
                    if (t.rw == 0) begin
                        bus_rvalid = 1'b1;
                        bus_err    = t.berr;
                        bus_rdata  = t.we ? $urandom : t.rdata;
                    end
                end
                req_cycles++;
            end else if (granted) begin
                after++;
                if (after == t.rw) begin
                    bus_rvalid = 1'b1;
                    bus_err    = t.berr;
                    bus_rdata  = t.we ? $urandom : t.rdata;
                end
            end
        end
        chk({nm, "_ack_cycle"}, 64'(ack_c), 64'(exp_c));
        chk({nm, "_req_cycles"}, 64'(req_cycles), 64'(exp_req));
        chk({nm, "_stall_done"}, 64'(core_stall), 64'd0);
        chk({nm, "_busreq_done"}, 64'(bus_req), 64'd0);
        core_req = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_bus_req"}, 64'(bus_req), 64'd0);
        chk({nm, "_bus_we"}, 64'(bus_we), 64'd0);
        chk({nm, "_bus_be"}, 64'(bus_be), 64'd0);
        chk({nm, "_bus_addr"}, 64'(bus_addr), 64'd0);
        chk({nm, "_bus_wdata"}, 64'(bus_wdata), 64'd0);
        chk({nm, "_core_ack"}, 64'(core_ack), 64'd0);
        chk({nm, "_core_err"}, 64'(core_err), 64'd0);
        chk({nm, "_core_rdata"}, 64'(core_rdata), 64'd0);
        chk({nm, "_core_stall"}, 64'(core_stall), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        vec_t r;
        //          we    mask   addr        wdata         gw rw rdata         berr  nobus tmo   err   exp_rdata
        vt[0]  = '{1'b0, 4'hF, 32'h100, 32'h0,        0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
        vt[1]  = '{1'b1, 4'h8, 32'h203, 32'h11000000, 0, 0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b0, 4'hF, 32'h102, 32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[3]  = '{1'b0, 4'hF, 32'h040, 32'h0,        1, 2, 32'h5555,     1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[4]  = '{1'b0, 4'hC, 32'h006, 32'h0,        2, 1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678};
        vt[5]  = '{1'b0, 4'h3, 32'h005, 32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678};
        vt[6]  = '{1'b0, 4'h0, 32'h010, 32'h0,        0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678};
        vt[7]  = '{1'b1, 4'h2, 32'h011, 32'h0000AB00, 0, 1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678};
        vt[8]  = '{1'b1, 4'hF, 32'h020, 32'h00000001, 0, 0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678};
        vt[9]  = '{1'b0, 4'hF, 32'h1FC, 32'h0,        0, 0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D};
        vt[10] = '{1'b0, 4'hF, 32'h080, 32'h0,        0, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D};
        vt[11] = '{1'b0, 4'h2, 32'h003, 32'h0,        1, 0, 32'h000000A5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000000A5};

        rst        = 1'b0;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_mask  = 4'h0;
        core_addr  = '0;
        core_wdata = '0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
        bus_rdata  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 12; i++)
            run_txn(vt[i], $sformatf("v%0d", i));

        // reset while a load sits in WAIT, then a stray rvalid after release
        @(negedge clk);
        core_req   = 1'b1;
        core_we    = 1'b0;
        core_mask  = 4'hF;
        core_addr  = 32'h300;
        core_wdata = '0;
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (bus_req) begin
                seen = 1;
                bus_gnt = 1'b1;
            end
        end
        chk("rstwait_req_seen", 64'(seen), 64'd1);
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("rstwait_in_wait_req", 64'(bus_req), 64'd0);
        chk("rstwait_in_wait_stall", 64'(core_stall), 64'd1);
        rst      = 1'b0;
        core_req = 1'b0;
        #1 check_all_zero("rstwait");
        @(negedge clk);
        rst        = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h77777777;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("stray_ack", 64'(core_ack), 64'd0);
        chk("stray_rdata", 64'(core_rdata), 64'd0);
        @(negedge clk);
        chk("stray_ack2", 64'(core_ack), 64'd0);
        chk("stray_busreq", 64'(bus_req), 64'd0);

        r = '{1'b0, 4'hF, 32'h304, 32'h0, 0, 1, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADF00D};
        run_txn(r, "post_rst");

        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
